imem_loader: RTL and testbench

//  Writer side of the byte-addressed, big-endian instruction store read by the fetch path.

---
 rtl/imem_loader.sv | 86 ++++++++
 tb/tb_imem_loader.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// imem_loader: splits 32-bit instruction words into big-endian byte writes for the instruction store
module imem_loader #(
  parameter logic [31:0] BASE_ADDR   = 32'd0,
  parameter int          DEPTH_BYTES = 80,
  parameter int          CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             word_valid,
  input  logic [31:0]      word_data,
  input  logic             word_last,
  output logic             word_ready,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [7:0]       mem_byte,
  output logic             loading,
  output logic             done,
  output logic             full,
  output logic [CNT_W-1:0] words_loaded
);
  typedef enum logic [2:0] {IDLE, ACCEPT, WR0, WR1, WR2, WR3, FIN} state_t;
  localparam logic [31:0] END_ADDR = BASE_ADDR + 32'(DEPTH_BYTES);
  state_t state, state_nx;
  logic [31:0] ptr, word, addr_q, addr_live, ptr_inc;
  logic [7:0] byte_q, byte_live;
  logic [1:0] k;
  logic last, wr, take;
  always_comb begin
    wr        = state inside {WR0, WR1, WR2, WR3};
    k         = state == WR1 ? 2'd1 : state == WR2 ? 2'd2 : state == WR3 ? 2'd3 : 2'd0;
    addr_live = ptr + {30'd0, k};
    byte_live = k == 2'd0 ? word[31:24] : k == 2'd1 ? word[23:16] : k == 2'd2 ? word[15:8] : word[7:0];
    ptr_inc   = ptr + 32'd4;
    take      = state == ACCEPT && word_valid && !start;
    state_nx  = state;
    if (start) state_nx = ACCEPT;
    else
      case (state)
        IDLE:    state_nx = IDLE;
        ACCEPT:  state_nx = take ? WR0 : ACCEPT;
        WR0:     state_nx = WR1;
        WR1:     state_nx = WR2;
        WR2:     state_nx = WR3;
        WR3:     state_nx = (last || ptr_inc == END_ADDR) ? FIN : ACCEPT;
        FIN:     state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
  end
  assign word_ready = state == ACCEPT;
  assign mem_we     = wr;
  assign mem_addr   = wr ? addr_live : addr_q;
  assign mem_byte   = wr ? byte_live : byte_q;
  assign loading    = state != IDLE && state != FIN;
  assign done       = state == FIN;
  // restart (start) takes priority over every in-flight action
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state        <= IDLE;
      ptr          <= BASE_ADDR;
      word         <= '0;
      last         <= 1'b0;
      addr_q       <= '0;
      byte_q       <= '0;
      full         <= 1'b0;
      words_loaded <= '0;
    end else begin
      state <= state_nx;
      if (wr) begin
        addr_q <= addr_live;
        byte_q <= byte_live;
      end
      if (start) begin
        ptr          <= BASE_ADDR;
        words_loaded <= '0;
        full         <= 1'b0;
      end else if (take) begin
        word <= word_data;
        last <= word_last;
      end else if (state == WR3) begin
        ptr          <= ptr_inc;
        words_loaded <= words_loaded + 1'b1;
        full         <= !last && ptr_inc == END_ADDR;
      end
    end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed/randomized bench against a byte-store reference model
module tb_imem_loader;
  logic clk = 0, rst_n = 0, start = 0, word_valid = 0, word_last = 0;
  logic [31:0] word_data = 0;
  logic word_ready, mem_we, loading, done, full;
  logic [31:0] mem_addr;
  logic [7:0] mem_byte, words_loaded;
  int n_cmp = 0, n_err = 0, cyc = 0, m_words = 0, last_acc = 0;
  logic [7:0] m_mem [0:79];
  logic [7:0] obs_mem [0:127];
  bit oob = 0;

  imem_loader dut (.clk(clk), .rst_n(rst_n), .start(start), .word_valid(word_valid),
    .word_data(word_data), .word_last(word_last), .word_ready(word_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_byte(mem_byte), .loading(loading), .done(done), .full(full),
    .words_loaded(words_loaded));

  always #5 clk = ~clk;

  always @(posedge clk)
    if (mem_we) begin
      if (mem_addr >= 32'd80) oob <= 1;
      else obs_mem[mem_addr[6:0]] <= mem_byte;
    end

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic begin_session();
    start = 1;
    step();
    start = 0;
    m_words = 0;
    chk("start_ready", word_ready, 1);
    chk("start_loading", loading, 1);
    chk("start_words", words_loaded, 0);
    chk("start_full", full, 0);
  endtask

  // one word through the loader; model: byte k of word n goes to address 4n+k, MSB first
  task automatic send_word(input logic [31:0] d, input logic l, input bit hold);
    int t = 0;
    logic [31:0] a;
    logic [7:0] b;
    bit ended;
    while (!word_ready && t < 20) begin step(); t++; end
    chk("ready_wait", word_ready, 1);
    word_valid = 1; word_data = d; word_last = l;
    step();
    if (m_words > 0 && hold) chk("spacing", cyc - last_acc, 5);
    last_acc = cyc;
    if (!hold) word_valid = 0;
    for (int k = 0; k < 4; k++) begin
      a = 32'(4 * m_words + k);
      b = 8'((d >> (24 - 8 * k)) & 32'hff);
      chk("we", mem_we, 1);
      chk("addr", mem_addr, a);
      chk("byte", mem_byte, b);
      chk("busy_ready", word_ready, 0);
      m_mem[a[6:0]] = b;
      step();
    end
    m_words++;
    ended = l || m_words == 20;
    chk("words", words_loaded, m_words);
    if (ended) begin
      word_valid = 0;
      chk("done", done, 1);
      chk("fin_loading", loading, 0);
      chk("fin_ready", word_ready, 0);
      chk("fin_we", mem_we, 0);
      chk("full", full, !l);
      step();
      chk("done_pulse", done, 0);
      chk("idle_ready", word_ready, 0);
      chk("addr_hold", mem_addr, 32'(4 * m_words - 1));
    end else begin
      chk("next_ready", word_ready, 1);
      chk("no_done", done, 0);
      chk("mid_full", full, 0);
    end
  endtask

  initial begin
    logic [31:0] w;
    int mis;
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w;
    int mis;
    repeat (3) step();
    chk("rst_ready", word_ready, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, 0);
    rst_n = 1;
    step();
    chk("idle_loading", loading, 0);
    chk("idle_words", words_loaded, 0);
    // reset asserted during WR2
    begin_session();
    word_valid = 1; word_data = $urandom; word_last = 0;
    step(); word_valid = 0;
    step(); step();
    chk("wr2_we", mem_we, 1);
    rst_n = 0;
    #1;
    chk("arst_we", mem_we, 0);
    chk("arst_loading", loading, 0);
    chk("arst_ready", word_ready, 0);
    chk("arst_done", done, 0);
    chk("arst_full", full, 0);
    chk("arst_words", words_loaded, 0);
    step(); step();
    rst_n = 1;
    step();
    chk("post_rst_idle", loading, 0);
    // single word session
    begin_session();
    send_word(32'h8E080000, 1, 0);
    // backpressure
    begin_session();
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_ready", word_ready, 1);
      chk("bp_we", mem_we, 0);
    end
    send_word(32'h01284820, 1, 0);
    // restart during WR1 of word 2
    begin_session();
    send_word($urandom, 0, 0);
    w = $urandom;
    word_valid = 1; word_data = w; word_last = 0;
    step(); word_valid = 0;
    step();
    chk("r_wr1_addr", mem_addr, 5);
    start = 1;
    step();
    start = 0;
    chk("r_we", mem_we, 0);
    chk("r_ready", word_ready, 1);
    chk("r_done", done, 0);
    chk("r_words", words_loaded, 0);
    m_words = 0;
    send_word($urandom, 1, 0);
    // throughput with word_valid held high
    begin_session();
    send_word($urandom, 0, 1);
    send_word($urandom, 0, 1);
    send_word($urandom, 1, 1);
    // fill the store with random gaps
    begin_session();
    for (int i = 0; i < 20; i++) begin
      repeat ($urandom_range(0, 2)) step();
      send_word($urandom, 0, 0);
    end
    // last word lands in the final slot
    begin_session();
    for (int i = 0; i < 20; i++) send_word($urandom, i == 19, 0);
    step();
    mis = 0;
    for (int i = 0; i < 80; i++) if (obs_mem[i] !== m_mem[i]) mis++;
    chk("store_bytes_wrong", mis, 0);
    chk("addr_out_of_range", oob, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
